// File: rtl/uart_frame_parser.sv
// Framing stage behind the UART RX FIFO: hunts for SOF, collects a length-prefixed
// payload with an additive checksum, and replays validated payloads as a valid/ready stream.
module uart_frame_parser #(
  parameter logic [7:0]  SOF     = 8'hA5,
  parameter int unsigned MAX_LEN = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  input  logic [7:0] fifo_rd_data,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       frame_ok,
  output logic       err_chk,
  output logic       err_len
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_DRAIN
  } state_t;

  state_t        state, state_next;
  logic          pending;
  logic [LW-1:0] len, len_next;
  logic [LW-1:0] idx, idx_next;
  logic [LW-1:0] rd_idx, rd_idx_next;
  logic [7:0]    sum, sum_next;
  logic          frame_ok_next, err_chk_next, err_len_next;
  logic          buf_we;
  logic          len_bad;
  logic          drain_last;
  logic [7:0]    payload_buf [MAX_LEN];

  // A byte is consumed exactly one cycle after its read strobe, so pending doubles as the consume flag.
  assign fifo_rd_en = !reset && !fifo_empty && !pending && (state != S_DRAIN);
  assign len_bad    = (fifo_rd_data == 8'h00) || ({24'h0, fifo_rd_data} > MAX_LEN);
  assign drain_last = ((rd_idx + LW'(1)) == len);

  assign out_valid = (state == S_DRAIN);
  assign out_last  = out_valid && drain_last;
  assign out_data  = out_valid ? payload_buf[rd_idx[IW-1:0]] : 8'h00;

  always_comb begin
    state_next    = state;
    len_next      = len;
    idx_next      = idx;
    rd_idx_next   = rd_idx;
    sum_next      = sum;
    frame_ok_next = 1'b0;
    err_chk_next  = 1'b0;
    err_len_next  = 1'b0;
    buf_we        = 1'b0;
    case (state)
      S_HUNT: begin
        if (pending && fifo_rd_data == SOF) state_next = S_LEN;
      end
      S_LEN: begin
        if (pending) begin
          if (len_bad) begin
            err_len_next = 1'b1;
            state_next   = S_HUNT;
          end else begin
            len_next   = fifo_rd_data[LW-1:0];
            sum_next   = fifo_rd_data;
            idx_next   = '0;
            state_next = S_PAYLOAD;
          end
        end
      end
      // SOF bytes inside the payload are plain data; no resync here.
      S_PAYLOAD: begin
        if (pending) begin
          buf_we   = 1'b1;
          sum_next = sum + fifo_rd_data;
          idx_next = idx + LW'(1);
          if ((idx + LW'(1)) == len) state_next = S_CHK;
        end
      end
      S_CHK: begin
        if (pending) begin
          if (fifo_rd_data == sum) begin
            frame_ok_next = 1'b1;
            rd_idx_next   = '0;
            state_next    = S_DRAIN;
          end else begin
            err_chk_next = 1'b1;
            state_next   = S_HUNT;
          end
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          rd_idx_next = rd_idx + LW'(1);
          if (drain_last) state_next = S_HUNT;
        end
      end
      default: state_next = S_HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_HUNT;
      pending  <= 1'b0;
      len      <= '0;
      idx      <= '0;
      rd_idx   <= '0;
      sum      <= 8'h00;
      frame_ok <= 1'b0;
      err_chk  <= 1'b0;
      err_len  <= 1'b0;
    end else begin
      state    <= state_next;
      pending  <= fifo_rd_en;
      len      <= len_next;
      idx      <= idx_next;
      rd_idx   <= rd_idx_next;
      sum      <= sum_next;
      frame_ok <= frame_ok_next;
      err_chk  <= err_chk_next;
      err_len  <= err_len_next;
    end
  end

  // Payload storage needs no reset; out_data is masked outside DRAIN.
  always_ff @(posedge clk) begin
    if (buf_we) payload_buf[idx[IW-1:0]] <= fifo_rd_data;
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: a queue-backed RX FIFO model feeds hand-built
// frames and a negedge monitor collects the output stream and status pulses.
module tb_uart_frame_parser;

  typedef logic [7:0] byte_q_t[$];
  typedef logic       bit_q_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fifo_empty = 1'b1;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data = 8'h00;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
  logic       frame_ok;
  logic       err_chk;
  logic       err_len;

  uart_frame_parser #(.SOF(8'hA5), .MAX_LEN(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .frame_ok    (frame_ok),
    .err_chk     (err_chk),
    .err_len     (err_len)
  );

  always #5 clk = ~clk;

  // RX FIFO model: registered read data and a registered empty flag.
  logic [7:0] fifo_q[$];
  always @(posedge clk) begin
    if (fifo_rd_en && fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Backpressure driver: in bp_mode each output byte waits 5 valid cycles before acceptance.
  logic bp_mode = 1'b0;
  int   stall_cnt = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!bp_mode) out_ready = 1'b1;
      else if (out_ready) begin
        out_ready = 1'b0;
        stall_cnt = 0;
      end else if (out_valid) begin
        stall_cnt++;
        if (stall_cnt == 5) out_ready = 1'b1;
      end
    end
  end

  int         n_ok, n_chk, n_len, n_valid, n_rd_in_drain, n_valid_busy, n_stall, n_stall_bad;
  logic [7:0] got_data[$];
  logic       got_last[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  always @(negedge clk) begin
    if (reset) prev_stall = 1'b0;
    else begin
      if (frame_ok) n_ok++;
      if (err_chk) n_chk++;
      if (err_len) n_len++;
      if (out_valid) n_valid++;
      if (out_valid && fifo_rd_en) n_rd_in_drain++;
      if (out_valid && !fifo_empty) n_valid_busy++;
      if (prev_stall) begin
        n_stall++;
        if (!out_valid || out_data != prev_data || out_last != prev_last) n_stall_bad++;
      end
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_vec++;
    if (observed !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearCounters();
    n_ok = 0; n_chk = 0; n_len = 0; n_valid = 0;
    n_rd_in_drain = 0; n_valid_busy = 0; n_stall = 0; n_stall_bad = 0;
    got_data.delete();
    got_last.delete();
  endtask

  task automatic applyStimulus(input byte_q_t bytes);
    @(posedge clk);
    #2;
    foreach (bytes[i]) fifo_q.push_back(bytes[i]);
  endtask

  task automatic waitIdle(input string tag);
    int quiet = 0;
    int cycles = 0;
    while (quiet < 4 && cycles < 3000) begin
      @(posedge clk);
      #2;
      cycles++;
      if (fifo_q.size() == 0 && fifo_empty && !out_valid && !fifo_rd_en) quiet++;
      else quiet = 0;
    end
    checkOutput({tag, "_idle"}, quiet, 4);
  endtask

  task automatic checkPulses(input string tag, input int ok, input int chk, input int len);
    checkOutput({tag, "_frame_ok"}, n_ok, ok);
    checkOutput({tag, "_err_chk"}, n_chk, chk);
    checkOutput({tag, "_err_len"}, n_len, len);
  endtask

  task automatic checkStream(input string tag, input byte_q_t ed, input bit_q_t el);
    checkOutput({tag, "_count"}, got_data.size(), ed.size());
    for (int i = 0; i < ed.size(); i++) begin
      if (i < got_data.size()) begin
        checkOutput($sformatf("%s_data%0d", tag, i), got_data[i], ed[i]);
        checkOutput($sformatf("%s_last%0d", tag, i), got_last[i], el[i]);
      end
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_rd_en"}, fifo_rd_en, 0);
    checkOutput({tag, "_valid"}, out_valid, 0);
    checkOutput({tag, "_last"}, out_last, 0);
    checkOutput({tag, "_data"}, out_data, 8'h00);
    checkOutput({tag, "_pulses"}, {frame_ok, err_chk, err_len}, 0);
  endtask

  byte_q_t stim, ed;
  bit_q_t  el;

  initial begin
    clearCounters();
    // A byte sits in the FIFO during reset; no read may be issued for it.
    fifo_q.push_back(8'h00);
    repeat (3) @(posedge clk);
    #2;
    checkResetOutputs("reset");
    reset = 1'b0;

    $display("[TB] good frame");
    clearCounters();
    stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    applyStimulus(stim);
    waitIdle("good");
    checkPulses("good", 1, 0, 0);
    ed = '{8'h11, 8'h22, 8'h33};
    el = '{1'b0, 1'b0, 1'b1};
    checkStream("good", ed, el);

    $display("[TB] garbage then bad checksum");
    clearCounters();
    stim = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    applyStimulus(stim);
    waitIdle("badchk");
    checkPulses("badchk", 0, 1, 0);
    checkOutput("badchk_valid_cycles", n_valid, 0);
    clearCounters();
    stim = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    applyStimulus(stim);
    waitIdle("after_badchk");
    checkPulses("after_badchk", 1, 0, 0);
    ed = '{8'h7E};
    el = '{1'b1};
    checkStream("after_badchk", ed, el);

    $display("[TB] length errors and max length");
    clearCounters();
    stim = '{8'hA5, 8'h00};
    applyStimulus(stim);
    waitIdle("len0");
    checkPulses("len0", 0, 0, 1);
    clearCounters();
    stim = '{8'hA5, 8'h11};
    applyStimulus(stim);
    waitIdle("len17");
    checkPulses("len17", 0, 0, 1);
    clearCounters();
    stim = '{8'hA5, 8'h10};
    ed.delete();
    el.delete();
    for (int i = 1; i <= 16; i++) begin
      stim.push_back(8'(i));
      ed.push_back(8'(i));
      el.push_back(i == 16);
    end
    stim.push_back(8'h98);
    applyStimulus(stim);
    waitIdle("len16");
    checkPulses("len16", 1, 0, 0);
    checkStream("len16", ed, el);

    $display("[TB] backpressure");
    clearCounters();
    bp_mode = 1'b1;
    stim = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0E, 8'hA5, 8'h01, 8'h55, 8'h56};
    applyStimulus(stim);
    waitIdle("bp");
    bp_mode = 1'b0;
    checkPulses("bp", 2, 0, 0);
    ed = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h55};
    el = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    checkStream("bp", ed, el);
    checkOutput("bp_stall_unstable", n_stall_bad, 0);
    checkOutput("bp_stall_cycles_ge20", n_stall >= 20, 1);
    checkOutput("bp_rd_in_drain", n_rd_in_drain, 0);
    checkOutput("bp_fifo_busy_in_drain", n_valid_busy > 0, 1);

    $display("[TB] payload contains SOF");
    clearCounters();
    stim = '{8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h4C};
    applyStimulus(stim);
    waitIdle("sofdata");
    checkPulses("sofdata", 1, 0, 0);
    ed = '{8'hA5, 8'hA5};
    el = '{1'b0, 1'b1};
    checkStream("sofdata", ed, el);

    $display("[TB] reset mid payload");
    clearCounters();
    stim = '{8'hA5, 8'h05, 8'h01, 8'h02};
    applyStimulus(stim);
    waitIdle("midrst_pre");
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkResetOutputs("midrst");
    foreach (stim[i]) stim.delete();
    stim = '{8'h03, 8'h04, 8'h05, 8'h14};
    foreach (stim[i]) fifo_q.push_back(stim[i]);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("midrst_rd_en_held", fifo_rd_en, 0);
    checkOutput("midrst_fifo_nonempty", fifo_empty, 0);
    reset = 1'b0;
    clearCounters();
    waitIdle("midrst_tail");
    checkPulses("midrst_tail", 0, 0, 0);
    checkOutput("midrst_tail_count", got_data.size(), 0);
    clearCounters();
    stim = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    applyStimulus(stim);
    waitIdle("midrst_next");
    checkPulses("midrst_next", 1, 0, 0);
    ed = '{8'h7E};
    el = '{1'b1};
    checkStream("midrst_next", ed, el);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
